// File: rtl/tc_2_sd_if.sv
// Stream bundle for tc_2_sd: two's-complement words in, sign-magnitude words out.
// The master side is the producer/consumer around the block; the slave side is tc_2_sd itself.
interface tc_2_sd_if #(
  parameter int bits = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [bits-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [bits-1:0] out_data;
  logic            out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/tc_2_sd.sv
// Two's-complement to sign-magnitude converter, 2-stage valid/ready pipeline.
// Stage 1 conditionally inverts the low bits; stage 2 adds the sign back in as the +1.
module tc_2_sd #(
  parameter int bits  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  tc_2_sd_if.slave         bus,
  output logic [CNT_W-1:0] ovf_cnt
);
  localparam logic [bits-1:0] MIN_NEG = {1'b1, {(bits-1){1'b0}}};

  logic            r_s1_valid;
  logic            r_s1_sign;
  logic            r_s1_ovf;
  logic [bits-2:0] r_s1_low;
  logic            r_s2_valid;
  logic [bits-1:0] r_out_data;
  logic            r_out_ovf;
  logic [CNT_W-1:0] r_ovf_cnt;

  logic w_s2_adv;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  always_comb begin
    w_s2_adv   = r_s1_valid & (~r_s2_valid | bus.out_ready);
    w_in_ready = ~r_s1_valid | w_s2_adv;
    w_in_fire  = bus.in_valid & w_in_ready;
    w_out_fire = r_s2_valid & bus.out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_low   <= '0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_sign <= bus.in_data[bits-1];
        r_s1_low  <= bus.in_data[bits-1] ? ~bus.in_data[bits-2:0] : bus.in_data[bits-2:0];
        r_s1_ovf  <= (bus.in_data == MIN_NEG);
      end
      r_s1_valid <= w_in_fire | (r_s1_valid & ~w_s2_adv);

      // Carry out of the magnitude add is dropped: -2^(bits-1) wraps to "-0".
      if (w_s2_adv) begin
        r_out_data <= {r_s1_sign, r_s1_low + (bits-1)'(r_s1_sign)};
        r_out_ovf  <= r_s1_ovf;
      end
      r_s2_valid <= w_s2_adv | (r_s2_valid & ~bus.out_ready);

      if (w_out_fire && r_out_ovf && (r_ovf_cnt != '1))
        r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign ovf_cnt       = r_ovf_cnt;
endmodule

// File: tb/tb_tc_2_sd.sv
// Scoreboard bench for tc_2_sd: an 8-bit instance for directed cases and a
// 32-bit instance for a randomised stream against a reference model.
module tb_tc_2_sd;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tc_2_sd_if #(.bits(8))  ba ();
  tc_2_sd_if #(.bits(32)) bb ();
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  tc_2_sd #(.bits(8), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .bus(ba), .ovf_cnt(cnt_a)
  );
  tc_2_sd #(.bits(32), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .bus(bb), .ovf_cnt(cnt_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        ovf;
  } exp_t;

  exp_t qa[$];
  int   qa_t[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lat_chk = 0;
  int   del_a   = 0;
  int   acc_b   = 0;
  int   del_b   = 0;
  int   ovf_b   = 0;
  exp_t ea, eb;
  int   ta;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model32(input logic [31:0] x);
    exp_t r;
    logic [31:0] n;
    n     = -x;
    r.d   = x[31] ? {1'b1, n[30:0]} : x;
    r.ovf = (x == 32'h8000_0000);
    return r;
  endfunction

  // Output monitors: pop expected value whenever an output transfer happens
  always @(negedge clk) begin
    if (!rst && ba.out_valid && ba.out_ready) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_spurious_out: got %0h expected no output", ba.out_data);
      end else begin
        ea = qa.pop_front();
        ta = qa_t.pop_front();
        check("a_data", 64'(ba.out_data), 64'(ea.d[7:0]));
        check("a_ovf", 64'(ba.out_ovf), 64'(ea.ovf));
        if (lat_chk != 0) check("a_latency", 64'(cyc - ta), 64'd2);
        del_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bb.out_valid && bb.out_ready) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_spurious_out: got %0h expected no output", bb.out_data);
      end else begin
        eb = qb.pop_front();
        check("b_data", 64'(bb.out_data), 64'(eb.d));
        check("b_ovf", 64'(bb.out_ovf), 64'(eb.ovf));
        if (eb.ovf) ovf_b++;
        del_b++;
      end
    end
  end

  // Present one word, push its hand-computed result when accepted; leaves in_valid high
  task automatic send_a(input logic [7:0] d, input logic [7:0] ed, input logic eo);
    int   k;
    exp_t e;
    ba.in_valid = 1'b1;
    ba.in_data  = d;
    k = 0;
    @(negedge clk);
    while (!ba.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!ba.in_ready) begin
      check("a_accept_timeout", 64'(ba.in_ready), 64'd1);
    end else begin
      e.d   = {24'h0, ed};
      e.ovf = eo;
      qa.push_back(e);
      qa_t.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    int k;
    k = 0;
    while ((qa.size() != 0 || ba.out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("a_drain", 64'(qa.size()), 64'd0);
  endtask

  logic [7:0] t1_in  [5] = '{8'h05, 8'hFB, 8'h7F, 8'h81, 8'h00};
  logic [7:0] t1_exp [5] = '{8'h05, 8'h85, 8'h7F, 8'hFF, 8'h00};

  initial begin
    int   del0;
    int   k;
    int   took;
    exp_t e;
    rst = 1'b1;
    ba.in_valid = 1'b0; ba.in_data = '0; ba.out_ready = 1'b1;
    bb.in_valid = 1'b0; bb.in_data = '0; bb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(ba.out_valid), 64'd0);
    check("rst_out_data", 64'(ba.out_data), 64'd0);
    check("rst_out_ovf", 64'(ba.out_ovf), 64'd0);
    check("rst_ovf_cnt", 64'(cnt_a), 64'd0);
    check("rst_in_ready", 64'(ba.in_ready), 64'd1);

    // 1: streaming conversions, fixed 2-cycle latency
    @(posedge clk); #1;
    lat_chk = 1;
    for (int i = 0; i < 5; i++) send_a(t1_in[i], t1_exp[i], 1'b0);
    ba.in_valid = 1'b0;
    drain_a();
    lat_chk = 0;

    // 2: most negative value
    @(posedge clk); #1;
    send_a(8'h80, 8'h80, 1'b1);
    ba.in_valid = 1'b0;
    check("t2_cnt_before", 64'(cnt_a), 64'd0);
    drain_a();
    check("t2_cnt_after", 64'(cnt_a), 64'd1);

    // 3: backpressure fills both stages, third word waits
    @(posedge clk); #1;
    ba.out_ready = 1'b0;
    del0 = del_a;
    send_a(8'h12, 8'h12, 1'b0);
    send_a(8'hFE, 8'h82, 1'b0);
    ba.in_valid = 1'b1;
    ba.in_data  = 8'h80;
    @(negedge clk);
    check("t3_in_ready_low", 64'(ba.in_ready), 64'd0);
    check("t3_out_valid", 64'(ba.out_valid), 64'd1);
    check("t3_out_data_first", 64'(ba.out_data), 64'h12);
    repeat (3) @(negedge clk);
    check("t3_in_ready_still_low", 64'(ba.in_ready), 64'd0);
    check("t3_out_data_stable", 64'(ba.out_data), 64'h12);
    check("t3_out_ovf_stable", 64'(ba.out_ovf), 64'd0);
    @(posedge clk); #1;
    ba.out_ready = 1'b1;
    send_a(8'h80, 8'h80, 1'b1);
    ba.in_valid = 1'b0;
    drain_a();
    check("t3_delivered", 64'(del_a - del0), 64'd3);
    check("t3_cnt", 64'(cnt_a), 64'd2);

    // 4: counter saturates
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send_a(8'h80, 8'h80, 1'b1);
    ba.in_valid = 1'b0;
    drain_a();
    check("t4_cnt_sat", 64'(cnt_a), 64'hF);
    repeat (3) @(negedge clk);
    check("t4_cnt_hold", 64'(cnt_a), 64'hF);

    // 5: reset with both stages full flushes everything
    @(posedge clk); #1;
    ba.out_ready = 1'b0;
    send_a(8'h33, 8'h33, 1'b0);
    send_a(8'h9C, 8'hE4, 1'b0);
    ba.in_valid = 1'b0;
    check("t5_full_in_ready", 64'(ba.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    qa_t.delete();
    @(negedge clk);
    check("t5_out_valid", 64'(ba.out_valid), 64'd0);
    check("t5_ovf_cnt", 64'(cnt_a), 64'd0);
    check("t5_in_ready", 64'(ba.in_ready), 64'd1);
    ba.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_no_output", 64'(ba.out_valid), 64'd0);

    // 6: random handshakes on the 32-bit instance
    @(posedge clk); #1;
    took = 0;
    for (int c = 0; c < 20000 && acc_b < 2000; c++) begin
      if (c != 0) begin
        @(posedge clk); #1;
      end
      bb.out_ready = ($urandom_range(0, 3) != 0);
      if (!bb.in_valid || took != 0) begin
        took = 0;
        bb.in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       bb.in_data = 32'h8000_0000;
          1:       bb.in_data = 32'h0000_0000;
          2:       bb.in_data = 32'h7FFF_FFFF;
          3:       bb.in_data = 32'hFFFF_FFFF;
          default: bb.in_data = $urandom;
        endcase
      end
      @(negedge clk);
      if (bb.in_valid && bb.in_ready) begin
        e = model32(bb.in_data);
        qb.push_back(e);
        acc_b++;
        took = 1;
      end
    end
    @(posedge clk); #1;
    bb.in_valid  = 1'b0;
    bb.out_ready = 1'b1;
    k = 0;
    while ((qb.size() != 0 || bb.out_valid) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t6_accepted", 64'(acc_b), 64'd2000);
    check("t6_acc_eq_del", 64'(del_b), 64'(acc_b));
    check("t6_ovf_cnt", 64'(cnt_b), 64'(ovf_b));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
